branch_resolve: RTL and testbench
=================================

# branch_resolve

EX-stage branch resolution unit for the RISC-V core. It drives the branch comparator's signed/unsigned select (`BrUn`) and consumes its `BrLT`/`BrEq` results. It decodes the branch condition and, for taken branches and jumps, issues a registered PC redirect to fetch over a valid/ready handshake. It then holds a pipeline flush for a programmable number of cycles. The core statically predicts not-taken, so every taken branch or jump causes a redirect.

## Interface
Parameters:
- `XLEN`, 32, datapath and PC width
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after the redirect handshake completes (0 allowed)
- `CNT_W`, 16, width of the statistics counters

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `br_valid`  in  1  EX holds a branch/jump instruction
- `br_ready`  out  1  instruction accepted this cycle
- `br_funct3`  in  3  B-type funct3
- `br_is_jal`  in  1  instruction is JAL
- `br_is_jalr`  in  1  instruction is JALR
- `br_target`  in  XLEN  computed target address
- `BrUn`  out  1  comparator unsigned select (combinational)
- `BrLT`  in  1  comparator less-than
- `BrEq`  in  1  comparator equal
- `redir_valid`  out  1  redirect request to fetch
- `redir_pc`  out  XLEN  redirect address
- `redir_ready`  in  1  fetch accepts redirect
- `flush`  out  1  squash IF/ID
- `illegal`  out  1  one-cycle pulse: funct3 010/011 accepted
- `br_cnt`  out  CNT_W  accepted branch/jump count, wraps
- `taken_cnt`  out  CNT_W  taken count, wraps

## Operation
- `BrUn = br_valid & ~br_is_jal & ~br_is_jalr & br_funct3[1]`. It is 0 otherwise.
- Taken decode by funct3:
  - 000 BEQ: `BrEq`
  - 001 BNE: `~BrEq`
  - 100 BLT / 110 BLTU: `BrLT`
  - 101 BGE / 111 BGEU: `~BrLT`
  - 010/011: not taken, and `illegal` pulses the next cycle
- JAL/JALR are always taken, regardless of `BrLT`/`BrEq`/funct3. For JALR, the redirect target has bit 0 cleared. If both jump flags are set, JALR wins.
- Accept: `br_valid & br_ready`. `br_cnt` increments on every accept. `taken_cnt` increments on taken accepts.
- FSM states are IDLE, REDIRECT and FLUSH:
  - IDLE: `br_ready=1`, `redir_valid=0`, `flush=0`. A taken accept latches `redir_pc` and moves to REDIRECT. A not-taken accept stays in IDLE.
  - REDIRECT: `br_ready=0`, `redir_valid=1`, `flush=1`, and `redir_pc` is stable. On `redir_ready`, it loads the down-counter with `FLUSH_CYCLES` and moves to FLUSH, or to IDLE if `FLUSH_CYCLES=0`.
  - FLUSH: `br_ready=0`, `flush=1`, and the counter decrements each cycle. When the counter reaches 1, the next state is IDLE.
- The counter is `$clog2(FLUSH_CYCLES+1)` bits wide, with a minimum of 1.

## Timing
- Reset values: state IDLE; `redir_valid=0`, `redir_pc=0`, `flush=0`, `illegal=0`, `br_cnt=0`, `taken_cnt=0`. `br_ready` is 1 after reset.
- Decision is combinational in the accept cycle, because the comparator is combinational. All outputs except `BrUn` and `br_ready` are registered.
- `redir_valid` and `flush` rise 1 cycle after the taken accept.
- `flush` high duration = (REDIRECT cycles) + `FLUSH_CYCLES`.
- `redir_valid`/`redir_pc` must hold until `redir_ready`. Deasserting `redir_ready` adds stall cycles with no change to outputs.
- `br_valid` while `br_ready=0` is not accepted, and no counter changes. EX must hold the instruction.
- The first IDLE cycle after FLUSH may accept a new branch, so back-to-back branches are allowed.
- Counters wrap from 2^CNT_W−1 to 0.
- Reset asserted in any state forces IDLE immediately (asynchronously). `redir_valid` and `flush` drop without waiting for a clock edge.

## Structure
- Shared package `riscv_pkg`:
  - funct3 constants `F3_BEQ..F3_BGEU`
  - enum `br_state_e {BR_IDLE, BR_REDIRECT, BR_FLUSH}`
  - `XLEN` default
- One sub-module, `branch_cond`: a purely combinational funct3/jump decode producing `BrUn`, `taken` and `illegal`. It is reused by any future branch predictor check.

## Test plan
- BEQ, A=B=20 (comparator instantiated in the bench), target 0x0000_0100, `redir_ready=1` → `BrUn=0`. `redir_valid=1` with `redir_pc=0x100` for 1 cycle; `flush` high 3 cycles; `taken_cnt=1`.
- BLTU, A=−15 (0xFFFF_FFF1), B=10 → `BrUn=1`, not taken. No redirect, `br_cnt=1`, `taken_cnt=0`. BLT with the same operands → `BrUn=0`, taken.
- JALR, target 0x0000_0203, `redir_ready` low for 4 cycles → `redir_pc=0x202` held stable. `flush` high for 5+2 cycles; `br_ready=0` throughout, and a second `br_valid` is not counted.
- funct3=011 → not taken, `illegal` pulses exactly 1 cycle, `br_cnt` increments.
- `rst_n` low mid-REDIRECT → `redir_valid`, `flush` and the counters go to 0 before the next edge. After release, `br_ready=1`.
- `FLUSH_CYCLES=0` build, two taken BGE branches back-to-back → `flush` high exactly 1 cycle per branch. The second branch is accepted on the cycle after the first handshake.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: branch funct3 encodings, branch-resolve
// FSM states and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_REDIRECT,
    BR_FLUSH
  } br_state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode: comparator signed/unsigned select,
// taken decision and illegal-funct3 flag. Jumps are always taken.
module branch_cond
  import riscv_pkg::*;
(
  input  logic       valid,
  input  logic [2:0] funct3,
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic       br_lt,
  input  logic       br_eq,
  output logic       br_un,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    br_un   = valid & ~is_jal & ~is_jalr & funct3[1];
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_jal || is_jalr) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        F3_BEQ:           taken = br_eq;
        F3_BNE:           taken = ~br_eq;
        F3_BLT, F3_BLTU:  taken = br_lt;
        F3_BGE, F3_BGEU:  taken = ~br_lt;
        default:          illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: decodes the branch outcome, issues a registered
// PC redirect over valid/ready, then holds flush for FLUSH_CYCLES cycles.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic             br_is_jal,
  input  logic             br_is_jalr,
  input  logic [XLEN-1:0]  br_target,
  output logic             BrUn,
  input  logic             BrLT,
  input  logic             BrEq,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  input  logic             redir_ready,
  output logic             flush,
  output logic             illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  br_state_e         state_q, state_d;
  logic [FC_W-1:0]   cnt_q, cnt_d;
  logic              redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              flush_q, flush_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  logic dec_taken;
  logic dec_illegal;
  logic accept;

  branch_cond u_cond (
    .valid   (br_valid),
    .funct3  (br_funct3),
    .is_jal  (br_is_jal),
    .is_jalr (br_is_jalr),
    .br_lt   (BrLT),
    .br_eq   (BrEq),
    .br_un   (BrUn),
    .taken   (dec_taken),
    .illegal (dec_illegal)
  );

  assign br_ready = (state_q == BR_IDLE);
  assign accept   = br_valid & br_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    flush_d       = flush_q;
    illegal_d     = accept & dec_illegal;
    br_cnt_d      = accept ? br_cnt_q + 1'b1 : br_cnt_q;
    taken_cnt_d   = (accept && dec_taken) ? taken_cnt_q + 1'b1 : taken_cnt_q;

    case (state_q)
      BR_IDLE: begin
        if (accept && dec_taken) begin
          state_d       = BR_REDIRECT;
          redir_valid_d = 1'b1;
          flush_d       = 1'b1;
          // JALR targets have bit 0 forced to zero; JALR wins over JAL.
          redir_pc_d    = br_is_jalr ? (br_target & ~XLEN'(1)) : br_target;
        end
      end
      BR_REDIRECT: begin
        if (redir_ready) begin
          redir_valid_d = 1'b0;
          if (FLUSH_CYCLES == 0) begin
            state_d = BR_IDLE;
            flush_d = 1'b0;
          end else begin
            state_d = BR_FLUSH;
            cnt_d   = FC_W'(FLUSH_CYCLES);
          end
        end
      end
      BR_FLUSH: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == FC_W'(1)) begin
          state_d = BR_IDLE;
          flush_d = 1'b0;
        end
      end
      default: begin
        state_d       = BR_IDLE;
        redir_valid_d = 1'b0;
        flush_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BR_IDLE;
      cnt_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      illegal_q     <= 1'b0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      illegal_q     <= illegal_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign flush       = flush_q;
  assign illegal     = illegal_q;
  assign br_cnt      = br_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a FLUSH_CYCLES=2 instance and a
// FLUSH_CYCLES=0 instance, each fed by its own behavioural comparator.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [2:0]  funct3 = '0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic [31:0] target = '0;

  logic        v_a = 1'b0;
  logic        rr_a = 1'b1;
  logic        ready_a, brun_a, lt_a, eq_a, rv_a, flush_a, ill_a;
  logic [31:0] pc_a;
  logic [15:0] brc_a, tkc_a;

  logic        v_z = 1'b0;
  logic        rr_z = 1'b1;
  logic        ready_z, brun_z, lt_z, eq_z, rv_z, flush_z, ill_z;
  logic [31:0] pc_z;
  logic [15:0] brc_z, tkc_z;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign eq_a = (op_a == op_b);
  assign lt_a = brun_a ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
  assign eq_z = (op_a == op_b);
  assign lt_z = brun_z ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(v_a), .br_ready(ready_a),
    .br_funct3(funct3), .br_is_jal(is_jal), .br_is_jalr(is_jalr),
    .br_target(target), .BrUn(brun_a), .BrLT(lt_a), .BrEq(eq_a),
    .redir_valid(rv_a), .redir_pc(pc_a), .redir_ready(rr_a),
    .flush(flush_a), .illegal(ill_a), .br_cnt(brc_a), .taken_cnt(tkc_a)
  );

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .br_valid(v_z), .br_ready(ready_z),
    .br_funct3(funct3), .br_is_jal(is_jal), .br_is_jalr(is_jalr),
    .br_target(target), .BrUn(brun_z), .BrLT(lt_z), .BrEq(eq_z),
    .redir_valid(rv_z), .redir_pc(pc_z), .redir_ready(rr_z),
    .flush(flush_z), .illegal(ill_z), .br_cnt(brc_z), .taken_cnt(tkc_z)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready_a); end
    n_vec++; if (rv_a !== 1'b0) begin n_err++; $display("FAIL reset_rv got=%b exp=0", rv_a); end
    n_vec++; if (pc_a !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", pc_a); end
    n_vec++; if (flush_a !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%b exp=0", flush_a); end
    n_vec++; if (ill_a !== 1'b0) begin n_err++; $display("FAIL reset_illegal got=%b exp=0", ill_a); end
    n_vec++; if (brc_a !== 16'd0 || tkc_a !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", brc_a, tkc_a); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", ready_a); end
  endtask

  task automatic test_beq();
    int fl = 0, rv = 0;
    @(negedge clk);
    op_a = 32'd20; op_b = 32'd20; funct3 = 3'b000; target = 32'h0000_0100;
    rr_a = 1'b1; v_a = 1'b1;
    #1;
    n_vec++; if (brun_a !== 1'b0) begin n_err++; $display("FAIL beq_brun got=%b exp=0", brun_a); end
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL beq_ready got=%b exp=1", ready_a); end
    @(negedge clk);
    v_a = 1'b0;
    n_vec++; if (rv_a !== 1'b1 || pc_a !== 32'h100) begin n_err++; $display("FAIL beq_redir got=%b/%h exp=1/00000100", rv_a, pc_a); end
    n_vec++; if (tkc_a !== 16'd1 || brc_a !== 16'd1) begin n_err++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", brc_a, tkc_a); end
    fl = int'(flush_a); rv = int'(rv_a);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      fl += int'(flush_a); rv += int'(rv_a);
    end
    n_vec++; if (fl != 3) begin n_err++; $display("FAIL beq_flush_len got=%0d exp=3", fl); end
    n_vec++; if (rv != 1) begin n_err++; $display("FAIL beq_redir_len got=%0d exp=1", rv); end
  endtask

  task automatic test_unsigned_signed();
    @(negedge clk);
    op_a = 32'hFFFF_FFF1; op_b = 32'd10; funct3 = 3'b110; target = 32'h0000_0300; v_a = 1'b1;
    #1;
    n_vec++; if (brun_a !== 1'b1) begin n_err++; $display("FAIL bltu_brun got=%b exp=1", brun_a); end
    @(negedge clk);
    v_a = 1'b0;
    n_vec++; if (rv_a !== 1'b0 || flush_a !== 1'b0) begin n_err++; $display("FAIL bltu_no_redir got=%b/%b exp=0/0", rv_a, flush_a); end
    n_vec++; if (brc_a !== 16'd2 || tkc_a !== 16'd1) begin n_err++; $display("FAIL bltu_cnt got=%0d/%0d exp=2/1", brc_a, tkc_a); end
    @(negedge clk);
    funct3 = 3'b100; v_a = 1'b1;
    #1;
    n_vec++; if (brun_a !== 1'b0) begin n_err++; $display("FAIL blt_brun got=%b exp=0", brun_a); end
    @(negedge clk);
    v_a = 1'b0;
    n_vec++; if (rv_a !== 1'b1 || pc_a !== 32'h300) begin n_err++; $display("FAIL blt_redir got=%b/%h exp=1/00000300", rv_a, pc_a); end
    n_vec++; if (brc_a !== 16'd3 || tkc_a !== 16'd2) begin n_err++; $display("FAIL blt_cnt got=%0d/%0d exp=3/2", brc_a, tkc_a); end
    repeat (4) @(negedge clk);
    n_vec++; if (ready_a !== 1'b1 || flush_a !== 1'b0) begin n_err++; $display("FAIL blt_idle got=%b/%b exp=1/0", ready_a, flush_a); end
  endtask

  task automatic test_jalr_stall();
    int fl = 0, rv = 0;
    @(negedge clk);
    is_jalr = 1'b1; funct3 = 3'b110; target = 32'h0000_0203; rr_a = 1'b0; v_a = 1'b1;
    #1;
    n_vec++; if (brun_a !== 1'b0) begin n_err++; $display("FAIL jalr_brun got=%b exp=0", brun_a); end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      fl += int'(flush_a); rv += int'(rv_a);
      if (i <= 5) begin
        n_vec++;
        if (rv_a !== 1'b1 || pc_a !== 32'h202 || ready_a !== 1'b0) begin
          n_err++; $display("FAIL jalr_hold[%0d] got=%b/%h/%b exp=1/00000202/0", i, rv_a, pc_a, ready_a);
        end
      end
      if (i == 5) begin rr_a = 1'b1; v_a = 1'b0; is_jalr = 1'b0; end
    end
    n_vec++; if (fl != 7) begin n_err++; $display("FAIL jalr_flush_len got=%0d exp=7", fl); end
    n_vec++; if (rv != 5) begin n_err++; $display("FAIL jalr_redir_len got=%0d exp=5", rv); end
    n_vec++; if (brc_a !== 16'd4 || tkc_a !== 16'd3) begin n_err++; $display("FAIL jalr_cnt got=%0d/%0d exp=4/3", brc_a, tkc_a); end
  endtask

  task automatic test_illegal();
    int pulses = 0;
    @(negedge clk);
    funct3 = 3'b011; v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
    n_vec++; if (ill_a !== 1'b1 || rv_a !== 1'b0) begin n_err++; $display("FAIL illegal_pulse got=%b/%b exp=1/0", ill_a, rv_a); end
    n_vec++; if (brc_a !== 16'd5 || tkc_a !== 16'd3) begin n_err++; $display("FAIL illegal_cnt got=%0d/%0d exp=5/3", brc_a, tkc_a); end
    pulses = int'(ill_a);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(ill_a);
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL illegal_len got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'd7; target = 32'h0000_0800; rr_a = 1'b0; v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
    n_vec++; if (rv_a !== 1'b1 || flush_a !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", rv_a, flush_a); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (rv_a !== 1'b0 || flush_a !== 1'b0) begin n_err++; $display("FAIL rstmid_async got=%b/%b exp=0/0", rv_a, flush_a); end
    n_vec++; if (brc_a !== 16'd0 || tkc_a !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", brc_a, tkc_a); end
    @(negedge clk);
    rst_n = 1'b1; rr_a = 1'b1;
    #1;
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", ready_a); end
  endtask

  task automatic test_back_to_back();
    int fl = 0;
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd5; op_b = 32'd3; target = 32'h0000_0400; rr_z = 1'b1; v_z = 1'b1;
    #1;
    n_vec++; if (brun_z !== 1'b0 || ready_z !== 1'b1) begin n_err++; $display("FAIL b2b_first got=%b/%b exp=0/1", brun_z, ready_z); end
    @(negedge clk);
    fl += int'(flush_z);
    n_vec++; if (rv_z !== 1'b1 || pc_z !== 32'h400 || flush_z !== 1'b1) begin n_err++; $display("FAIL b2b_redir1 got=%b/%h/%b exp=1/00000400/1", rv_z, pc_z, flush_z); end
    target = 32'h0000_0500;
    @(negedge clk);
    fl += int'(flush_z);
    n_vec++; if (ready_z !== 1'b1 || brc_z !== 16'd1 || flush_z !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b/%0d/%b exp=1/1/0", ready_z, brc_z, flush_z); end
    @(negedge clk);
    v_z = 1'b0;
    fl += int'(flush_z);
    n_vec++; if (rv_z !== 1'b1 || pc_z !== 32'h500 || brc_z !== 16'd2) begin n_err++; $display("FAIL b2b_redir2 got=%b/%h/%0d exp=1/00000500/2", rv_z, pc_z, brc_z); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fl += int'(flush_z);
    end
    n_vec++; if (fl != 2) begin n_err++; $display("FAIL b2b_flush_len got=%0d exp=2", fl); end
    n_vec++; if (tkc_z !== 16'd2 || brc_z !== 16'd2) begin n_err++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/2", brc_z, tkc_z); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_unsigned_signed();
    test_jalr_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
